// File: rtl/imm_gen_q_pkg.sv
// rtl/imm_gen_q_pkg.sv - shared immediate format codes and widths
package imm_gen_q_pkg;

    localparam int IMM_SEL_W = 3;

    typedef enum logic [IMM_SEL_W-1:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_Z  = 3'd5,
        IMM_SH = 3'd6,
        IMM_X  = 3'd7
    } imm_sel_e;

endpackage

// File: rtl/imm_gen_q_if.sv
// rtl/imm_gen_q_if.sv - instruction-in / immediate-out handshake bundle
interface imm_gen_q_if
    import imm_gen_q_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              inst_i;
    logic [IMM_SEL_W-1:0]     immsel_i;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          simm_o;
    logic                     err_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        output in_valid, inst_i, immsel_i, out_ready,
        input  in_ready, out_valid, simm_o, err_o, count_o
    );

    modport slave (
        input  in_valid, inst_i, immsel_i, out_ready,
        output in_ready, out_valid, simm_o, err_o, count_o
    );
endinterface

// File: rtl/imm_gen_q_fmt_decode.sv
// rtl/imm_gen_q_fmt_decode.sv - combinational RV immediate extract/extend
module imm_fmt_decode
    import imm_gen_q_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]          inst,
    input  logic [IMM_SEL_W-1:0] immsel,
    output logic [XLEN-1:0]      imm,
    output logic                 err
);
    // Built at 64 bits and truncated: sign extension to 64 then cut to 32
    // is identical to sign extension to 32.
    logic [63:0] w_ext;
    logic        w_unused;

    always_comb begin
        w_ext = '0;
        err   = 1'b0;
        case (imm_sel_e'(immsel))
            IMM_I:  w_ext = {{52{inst[31]}}, inst[31:20]};
            IMM_S:  w_ext = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:  w_ext = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:  w_ext = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J:  w_ext = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:  w_ext = {59'b0, inst[19:15]};
            IMM_SH: w_ext = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            default: begin
                w_ext = '0;
                err   = 1'b1;
            end
        endcase
    end

    assign imm      = w_ext[XLEN-1:0];
    assign w_unused = ^{inst[6:0], w_ext};
endmodule

// File: rtl/imm_gen_q.sv
// rtl/imm_gen_q.sv - immediate generator feeding a DEPTH-entry output queue
module imm_gen_q
    import imm_gen_q_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    imm_gen_q_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  r_mem_imm [DEPTH];
    logic             r_mem_err [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    imm_fmt_decode #(.XLEN(XLEN)) u_dec (
        .inst   (bus.inst_i),
        .immsel (bus.immsel_i),
        .imm    (w_imm),
        .err    (w_err)
    );

    // Handshake flags derive from the count register alone, so out_ready
    // never reaches in_ready combinationally.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.out_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_imm[r_wr_ptr] <= w_imm;
            r_mem_err[r_wr_ptr] <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.simm_o    = w_empty ? '0 : r_mem_imm[r_rd_ptr];
    assign bus.err_o     = w_empty ? 1'b0 : r_mem_err[r_rd_ptr];
    assign bus.count_o   = r_count;
endmodule

// File: tb/tb_imm_gen_q.sv
// tb/tb_imm_gen_q.sv - directed self-checking bench for imm_gen_q
module tb_imm_gen_q;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imm_gen_q_if #(.XLEN(64), .DEPTH(2)) bus64 ();
    imm_gen_q_if #(.XLEN(32), .DEPTH(2)) bus32 ();

    imm_gen_q #(.XLEN(64), .DEPTH(2)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
    imm_gen_q #(.XLEN(32), .DEPTH(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    task automatic test_reset();
        bus64.in_valid = 0; bus64.inst_i = '0; bus64.immsel_i = '0; bus64.out_ready = 1;
        bus32.in_valid = 0; bus32.inst_i = '0; bus32.immsel_i = '0; bus32.out_ready = 1;
        rst = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus64.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus64.in_ready); end
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus64.out_valid); end
        checks++; if (bus64.count_o !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus64.count_o); end
        checks++; if (bus64.simm_o !== 64'd0 || bus64.err_o !== 1'b0) begin errors++; $display("FAIL reset_head got=%h/%b exp=0/0", bus64.simm_o, bus64.err_o); end
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_formats();
        logic [31:0] insts [7];
        logic [2:0]  sels  [7];
        logic [63:0] exps  [7];
        insts[0] = 32'hFFF00093; sels[0] = 3'd0; exps[0] = 64'hFFFFFFFFFFFFFFFF;
        insts[1] = 32'hFE20BC23; sels[1] = 3'd1; exps[1] = 64'hFFFFFFFFFFFFFFF8;
        insts[2] = 32'hFE000EE3; sels[2] = 3'd2; exps[2] = 64'hFFFFFFFFFFFFFFFC;
        insts[3] = 32'h800000B7; sels[3] = 3'd3; exps[3] = 64'hFFFFFFFF80000000;
        insts[4] = 32'h001000EF; sels[4] = 3'd4; exps[4] = 64'h0000000000000800;
        insts[5] = 32'h000F8073; sels[5] = 3'd5; exps[5] = 64'h000000000000001F;
        insts[6] = 32'h03F00013; sels[6] = 3'd6; exps[6] = 64'h000000000000003F;
        bus64.out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            bus64.in_valid = 1; bus64.inst_i = insts[i]; bus64.immsel_i = sels[i];
            @(negedge clk);
            bus64.in_valid = 0; bus64.inst_i = 32'hFFFFFFFF; bus64.immsel_i = 3'd0;
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.simm_o !== exps[i] || bus64.err_o !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d got v=%b imm=%h err=%b exp v=1 imm=%h err=0", i, bus64.out_valid, bus64.simm_o, bus64.err_o, exps[i]);
            end
            @(negedge clk);
        end
        checks++; if (bus64.out_valid !== 1'b0 || bus64.simm_o !== 64'd0) begin errors++; $display("FAIL fmt_drained got v=%b imm=%h exp v=0 imm=0", bus64.out_valid, bus64.simm_o); end
    endtask

    task automatic test_xlen32();
        bus32.out_ready = 1;
        bus32.in_valid = 1; bus32.inst_i = 32'h800000B7; bus32.immsel_i = 3'd3;
        @(negedge clk);
        bus32.in_valid = 0;
        checks++; if (bus32.simm_o !== 32'h80000000 || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL x32_u got v=%b imm=%h exp v=1 imm=80000000", bus32.out_valid, bus32.simm_o); end
        @(negedge clk);
        bus32.in_valid = 1; bus32.inst_i = 32'h03F00013; bus32.immsel_i = 3'd6;
        @(negedge clk);
        bus32.in_valid = 0;
        checks++; if (bus32.simm_o !== 32'h0000001F || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL x32_sh got v=%b imm=%h exp v=1 imm=0000001f", bus32.out_valid, bus32.simm_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus64.out_ready = 0; bus64.immsel_i = 3'd0;
        bus64.in_valid = 1; bus64.inst_i = 32'h00100013;
        @(negedge clk);
        checks++; if (bus64.in_ready !== 1'b1 || bus64.count_o !== 2'd1) begin errors++; $display("FAIL bp_one got rdy=%b cnt=%0d exp rdy=1 cnt=1", bus64.in_ready, bus64.count_o); end
        bus64.inst_i = 32'h00200013;
        @(negedge clk);
        bus64.inst_i = 32'h00300013;
        checks++; if (bus64.in_ready !== 1'b0 || bus64.count_o !== 2'd2) begin errors++; $display("FAIL bp_full got rdy=%b cnt=%0d exp rdy=0 cnt=2", bus64.in_ready, bus64.count_o); end
        @(negedge clk);
        checks++; if (bus64.count_o !== 2'd2 || bus64.simm_o !== 64'd1) begin errors++; $display("FAIL bp_hold got cnt=%0d imm=%h exp cnt=2 imm=1", bus64.count_o, bus64.simm_o); end
        bus64.out_ready = 1;
        @(negedge clk);
        checks++; if (bus64.count_o !== 2'd1 || bus64.simm_o !== 64'd2 || bus64.in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 got cnt=%0d imm=%h rdy=%b exp cnt=1 imm=2 rdy=1", bus64.count_o, bus64.simm_o, bus64.in_ready); end
        @(negedge clk);
        bus64.in_valid = 0;
        checks++; if (bus64.count_o !== 2'd1 || bus64.simm_o !== 64'd3) begin errors++; $display("FAIL bp_third got cnt=%0d imm=%h exp cnt=1 imm=3", bus64.count_o, bus64.simm_o); end
        @(negedge clk);
        checks++; if (bus64.count_o !== 2'd0 || bus64.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got cnt=%0d v=%b exp cnt=0 v=0", bus64.count_o, bus64.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] v;
        logic [63:0] exp_imm;
        bus64.immsel_i = 3'd0; bus64.out_ready = 0;
        v = 12'h000;
        bus64.in_valid = 1; bus64.inst_i = {v, 20'h00013};
        @(negedge clk);
        bus64.out_ready = 1;
        for (int k = 1; k <= 9; k++) begin
            exp_imm = {{52{v[11]}}, v};
            checks++;
            if (bus64.count_o !== 2'd1 || bus64.simm_o !== exp_imm) begin
                errors++;
                $display("FAIL b2b%0d got cnt=%0d imm=%h exp cnt=1 imm=%h", k, bus64.count_o, bus64.simm_o, exp_imm);
            end
            v = 12'(12'h101 * k);
            bus64.inst_i = {v, 20'h00013};
            if (k == 9) bus64.in_valid = 0;
            @(negedge clk);
        end
        checks++; if (bus64.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%b exp v=0", bus64.out_valid); end
    endtask

    task automatic test_illegal();
        bus64.out_ready = 0;
        bus64.in_valid = 1; bus64.inst_i = 32'hFFF00093; bus64.immsel_i = 3'd7;
        @(negedge clk);
        bus64.immsel_i = 3'd0; bus64.inst_i = 32'h00500013;
        @(negedge clk);
        bus64.in_valid = 0;
        checks++; if (bus64.simm_o !== 64'd0 || bus64.err_o !== 1'b1) begin errors++; $display("FAIL illegal got imm=%h err=%b exp imm=0 err=1", bus64.simm_o, bus64.err_o); end
        bus64.out_ready = 1;
        @(negedge clk);
        checks++; if (bus64.simm_o !== 64'd5 || bus64.err_o !== 1'b0) begin errors++; $display("FAIL after_illegal got imm=%h err=%b exp imm=5 err=0", bus64.simm_o, bus64.err_o); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bus64.out_ready = 0; bus64.immsel_i = 3'd0;
        bus64.in_valid = 1; bus64.inst_i = 32'h00700013;
        repeat (2) @(negedge clk);
        bus64.in_valid = 0;
        checks++; if (bus64.count_o !== 2'd2) begin errors++; $display("FAIL rmid_setup got cnt=%0d exp cnt=2", bus64.count_o); end
        #2 rst = 0;
        #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.count_o !== 2'd0 || bus64.simm_o !== 64'd0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async got v=%b cnt=%0d imm=%h rdy=%b exp v=0 cnt=0 imm=0 rdy=1", bus64.out_valid, bus64.count_o, bus64.simm_o, bus64.in_ready);
        end
        @(negedge clk);
        rst = 1;
        bus64.in_valid = 1; bus64.inst_i = 32'h00900013;
        @(negedge clk);
        bus64.in_valid = 0;
        checks++; if (bus64.out_valid !== 1'b1 || bus64.simm_o !== 64'd9 || bus64.count_o !== 2'd1) begin errors++; $display("FAIL rmid_after got v=%b imm=%h cnt=%0d exp v=1 imm=9 cnt=1", bus64.out_valid, bus64.simm_o, bus64.count_o); end
        bus64.out_ready = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_formats();
        test_xlen32();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
